// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: hsync/vsync, active-video flag and pixel coordinates.
// Optional frame counter output enabled by defining VGA_SYNC_FRAME_CNT_EN.
module vga_sync_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clkdiv,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] x,
  output logic [9:0] y,
`ifdef VGA_SYNC_FRAME_CNT_EN
  output logic       frame_start,
  output logic [7:0] frame_cnt
`else
  output logic       frame_start
`endif
);

  localparam int unsigned CW           = 10;
  localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
  localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
  localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

  logic [CW-1:0] hcnt;
  logic [CW-1:0] vcnt;
  logic [CW-1:0] hcnt_nxt;
  logic [CW-1:0] vcnt_nxt;
  logic          h_active_c;
  logic          v_active_c;
  logic          h_sync_c;
  logic          v_sync_c;
  logic          origin_c;

  // Phase decode of the current counter position
  always_comb begin
    h_active_c = 32'(hcnt) < H_ACTIVE;
    v_active_c = 32'(vcnt) < V_ACTIVE;
    h_sync_c   = (32'(hcnt) >= H_SYNC_START) && (32'(hcnt) < H_SYNC_END);
    v_sync_c   = (32'(vcnt) >= V_SYNC_START) && (32'(vcnt) < V_SYNC_END);
    origin_c   = (hcnt == '0) && (vcnt == '0);
  end

  // Raster advance: wrap the line, then the frame
  always_comb begin
    hcnt_nxt = hcnt + CW'(1);
    vcnt_nxt = vcnt;
    if (32'(hcnt) == H_TOTAL - 1) begin
      hcnt_nxt = '0;
      if (32'(vcnt) == V_TOTAL - 1) begin
        vcnt_nxt = '0;
      end else begin
        vcnt_nxt = vcnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt        <= '0;
      vcnt        <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      x           <= '0;
      y           <= '0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (clkdiv) begin
        hcnt        <= hcnt_nxt;
        vcnt        <= vcnt_nxt;
        hsync       <= ~h_sync_c;
        vsync       <= ~v_sync_c;
        video_on    <= h_active_c & v_active_c;
        x           <= (h_active_c & v_active_c) ? hcnt : '0;
        y           <= (h_active_c & v_active_c) ? vcnt : '0;
        frame_start <= origin_c;
      end
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  // Counts frames on the same edge that raises frame_start
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
    end else if (clkdiv && origin_c) begin
      frame_cnt <= frame_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Scoreboard bench for vga_sync_gen on a reduced raster (20x8 totals, 160 ticks/frame).
module tb_vga_sync_gen;

  localparam int unsigned HA = 12, HF = 2, HS = 3, HB = 3;
  localparam int unsigned VA = 4,  VF = 1, VS = 2, VB = 1;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int FT  = HT * VT;
  localparam int MID = 2 * HT + 7;

  typedef struct {
    int hs; int vs; int von; int x; int y; int fs; int fc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clkdiv = 1'b0;
  logic       hsync, vsync, video_on, frame_start;
  logic [9:0] x, y;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [7:0] frame_cnt;
`endif

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk), .rst(rst), .clkdiv(clkdiv),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .x(x), .y(y),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_start(frame_start),
    .frame_cnt(frame_cnt)
`else
    .frame_start(frame_start)
`endif
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   pos = 0;
  int   fc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // Reference: linear pixel index within the frame mapped to (h,v) by division
  task automatic drive(input logic r, input logic cd);
    exp_t e;
    int h, v;
    @(negedge clk);
    rst = r;
    clkdiv = cd;
    if (r) begin
      pos = 0;
      fc = 0;
    end else if (cd) begin
      h = pos % HT;
      v = pos / HT;
      e.hs  = (h >= HA + HF && h < HA + HF + HS) ? 0 : 1;
      e.vs  = (v >= VA + VF && v < VA + VF + VS) ? 0 : 1;
      e.von = (h < HA && v < VA) ? 1 : 0;
      e.x   = e.von ? h : 0;
      e.y   = e.von ? v : 0;
      e.fs  = (pos == 0) ? 1 : 0;
      if (e.fs == 1) fc = (fc + 1) % 256;
      e.fc  = fc;
      q.push_back(e);
      pos = (pos + 1) % FT;
    end
  endtask

  task automatic cmp(input string tag, input exp_t e);
    chk({tag, "_hsync"}, int'(hsync), e.hs);
    chk({tag, "_vsync"}, int'(vsync), e.vs);
    chk({tag, "_video_on"}, int'(video_on), e.von);
    chk({tag, "_x"}, int'(x), e.x);
    chk({tag, "_y"}, int'(y), e.y);
    chk({tag, "_frame_start"}, int'(frame_start), e.fs);
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk({tag, "_frame_cnt"}, int'(frame_cnt), e.fc);
`endif
  endtask

  // Monitor: every tick presents a new output word; other cycles must hold
  always begin : monitor
    exp_t e;
    exp_t last;
    logic was_rst, was_tick;
    @(posedge clk);
    was_rst  = rst;
    was_tick = clkdiv && !rst;
    #1;
    if (was_rst) begin
      last = '{hs: 1, vs: 1, von: 0, x: 0, y: 0, fs: 0, fc: 0};
      cmp("reset", last);
    end else if (was_tick) begin
      if (q.size() == 0) begin
        chk("queue_underflow", 0, 1);
      end else begin
        e = q.pop_front();
        cmp("tick", e);
        last = e;
        last.fs = 0;
      end
    end else begin
      cmp("hold", last);
    end
  end

  initial begin : stimulus
    bit hit_mid;
    for (int i = 0; i < 8; i++) drive(1'b1, (i % 4) == 3);
    for (int i = 0; i < FT * 4; i++) drive(1'b0, (i % 4) == 0);
    for (int i = 0; i < FT * 4; i++) drive(1'b0, 1'($urandom_range(0, 1)));
    // Reset coincident with a tick at a mid-frame pixel
    hit_mid = 1'b0;
    for (int i = 0; i < FT * 8 && !hit_mid; i++) begin
      if ((i % 4) == 0 && pos == MID) begin
        drive(1'b1, 1'b1);
        hit_mid = 1'b1;
      end else begin
        drive(1'b0, (i % 4) == 0);
      end
    end
    chk("mid_reset_reached", int'(hit_mid), 1);
    for (int i = 0; i < FT * 2; i++) drive(1'b0, (i % 4) == 0);
    // Pixel enable tied high through a full frame-counter wrap
    for (int i = 0; i < FT * 257 + 10; i++) drive(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Pixel-timing generator for the VGA controller. Consumes the pixel-rate enable `clkdiv` produced by the 2-bit clock-divider counter and, in the same `clk` domain, produces `hsync`/`vsync`, the active-video flag and the current pixel coordinates for the downstream pixel/colour logic. Default parameters give 640x480 at 60 Hz with a 25 MHz pixel enable derived from a 100 MHz `clk`.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BP`, 48, horizontal back porch (pixels)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)

Ports:
- `clk` in 1: system clock; the only clock
- `rst` in 1: synchronous, active-high reset
- `clkdiv` in 1: pixel enable; one pixel step per `clk` cycle where high (a level input, never used as a clock)
- `hsync` out 1: horizontal sync, active low
- `vsync` out 1: vertical sync, active low
- `video_on` out 1: high while the output pixel is inside the visible area
- `x` out 10: pixel column, 0..H_ACTIVE-1 when `video_on`, else 0
- `y` out 10: pixel row, 0..V_ACTIVE-1 when `video_on`, else 0
- `frame_start` out 1: single-`clk` pulse when outputs present pixel (0,0)
- `frame_cnt` out 8: frame counter (only with `VGA_SYNC_FRAME_CNT_EN`)

## Operation
- Internal counters `hcnt` 0..H_TOTAL-1, `vcnt` 0..V_TOTAL-1, 10 bits each; H_TOTAL = sum of H params (800), V_TOTAL = sum of V params (525). Both totals must be ≤ 1024.
- Horizontal phase decode from `hcnt`: ACTIVE [0, H_ACTIVE), FRONT [H_ACTIVE, H_ACTIVE+H_FP), SYNC [.., +H_SYNC), BACK [.., H_TOTAL). Vertical decode identical with V params on `vcnt`.
- On a "tick" (`clkdiv`=1 and `rst`=0), in one edge:
  - outputs load the decode of the current (`hcnt`,`vcnt`): `hsync`=0 iff hcnt in SYNC (656..751 default); `vsync`=0 iff vcnt in SYNC (490..491); `video_on` = both ACTIVE; `x`/`y` = hcnt/vcnt if `video_on`, else 0; `frame_start`=1 iff hcnt=0 and vcnt=0.
  - counters advance: hcnt+1; at H_TOTAL-1, hcnt→0 and vcnt+1; at vcnt V_TOTAL-1 with line wrap, vcnt→0.
- Non-tick cycle: counters and `hsync`, `vsync`, `video_on`, `x`, `y` hold; `frame_start` forced to 0 (pulse never exceeds one `clk`).
- Reset: hcnt=0, vcnt=0, `hsync`=1, `vsync`=1, `video_on`=0, `x`=0, `y`=0, `frame_start`=0, `frame_cnt`=0. `rst` overrides a simultaneous `clkdiv`.
- Reset mid-frame: abandons the frame immediately; the next tick restarts at pixel (0,0) with `frame_start`.
- `clkdiv` tied high is legal: one pixel per `clk`.

## Timing
- Latency: outputs describe the counter value present at the tick; they are one tick behind the counters.
- First tick after reset release: `video_on`=1, `x`=0, `y`=0, `frame_start`=1.
- Line = H_TOTAL ticks; frame = H_TOTAL*V_TOTAL ticks (420000 default); `frame_start` period equals one frame exactly.
- With default 1-in-4 `clkdiv`, every output changes only on the `clk` edge of a tick and is stable for 4 `clk`, except `frame_start` (1 `clk`).
- All outputs registered; no combinational path from inputs to outputs.

## Configuration
- `VGA_SYNC_FRAME_CNT_EN` defined: `frame_cnt` port present; increments by 1 on the same edge that asserts `frame_start` (first frame after reset shows 1), wraps 255→0, reset to 0.
- Not defined: `frame_cnt` port and its register are absent; all other behaviour identical.

## Test plan
- Reset: assert `rst` 2 cycles with `clkdiv` toggling 1-in-4 → `hsync`=1, `vsync`=1, `video_on`=0, `x`=`y`=0, `frame_start`=0 throughout.
- First tick after release → `video_on`=1, (x,y)=(0,0), `frame_start` high exactly 1 `clk`; 639 ticks later x=639; next tick `video_on`=0, x=0.
- Horizontal sync: `hsync` low for exactly 96 ticks, first low output for hcnt=656, high again at hcnt=752; line period 800 ticks.
- Vertical/frame wrap: `vsync` low for lines 490–491 only (2*800 ticks); after 420000 ticks `frame_start` repeats and (x,y)=(0,0).
- Reset mid-frame at (x,y)=(300,200), `rst` coincident with a tick → reset wins; next tick shows (0,0) with `frame_start`.
- `clkdiv` tied high → line = 800 `clk`; with `VGA_SYNC_FRAME_CNT_EN`, `frame_cnt` reads 1 after first `frame_start`, wraps 255→0 on the 256th.
